// File: rtl/apb_req_bridge_if.sv
// -----------------------------------------------------------------------------
// apb_req_bridge_if
// Purpose : Groups the upstream valid/ready request/response port and the
//           downstream APB initiator signals of apb_req_bridge.
// Modports:
//   master - the bridge itself. It accepts requests, returns responses and
//            drives the APB completer.
//   slave  - the surroundings of the bridge. This is the LSU/crossbar on the
//            request side and the APB completer on the bus side.
// Signals : req_* / resp_*   upstream request/response handshake
//           out_*            APB3/APB4 initiator bus
// -----------------------------------------------------------------------------
interface apb_req_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // upstream request
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic [2:0]        req_prot;

  // upstream response
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  // APB bus
  logic [ADDR_W-1:0] out_paddr;
  logic              out_psel;
  logic              out_penable;
  logic [2:0]        out_pprot;
  logic              out_pwrite;
  logic [DATA_W-1:0] out_pwdata;
  logic [STRB_W-1:0] out_pstrb;
  logic              out_pready;
  logic [DATA_W-1:0] out_prdata;
  logic              out_pslverr;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output out_paddr, out_psel, out_penable, out_pprot, out_pwrite,
    output out_pwdata, out_pstrb,
    input  out_pready, out_prdata, out_pslverr
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  out_paddr, out_psel, out_penable, out_pprot, out_pwrite,
    input  out_pwdata, out_pstrb,
    output out_pready, out_prdata, out_pslverr
  );
endinterface

// File: rtl/apb_req_bridge.sv
// -----------------------------------------------------------------------------
// apb_req_bridge
// Purpose : APB initiator. It turns one valid/ready request into a single
//           SETUP->ACCESS transfer on an APB3/APB4 completer. It handles
//           wait states, propagates pslverr and has an optional watchdog
//           timeout.
// Ports   : clock  - system clock
//           reset  - synchronous, active-high
//           bus    - apb_req_bridge_if.master (request/response + APB bus)
// Params  : ADDR_W, DATA_W - must match the interface instance
//           TIMEOUT        - max ACCESS cycles without pready, 0 = disabled
// -----------------------------------------------------------------------------
module apb_req_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  apb_req_bridge_if.master     bus
);

  localparam int STRB_W = DATA_W / 8;
  // keep at least one bit so a disabled watchdog still elaborates cleanly
  localparam int CNT_W  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit USE_TO = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = USE_TO ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_psel;
  logic              r_penable;
  logic [2:0]        r_pprot;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic [STRB_W-1:0] r_pstrb;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_err;
  logic              w_req_ready;

  // Request acceptance is only possible in IDLE and never while reset is held.
  assign w_req_ready = (r_state == S_IDLE) && !reset;

  // Transfer sequencer: a single FSM owns every registered bus/response output.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= {CNT_W{1'b0}};
      r_paddr      <= {ADDR_W{1'b0}};
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pprot      <= 3'b000;
      r_pwrite     <= 1'b0;
      r_pwdata     <= {DATA_W{1'b0}};
      r_pstrb      <= {STRB_W{1'b0}};
      r_resp_valid <= 1'b0;
      r_resp_rdata <= {DATA_W{1'b0}};
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_paddr   <= bus.req_addr;
            r_pwrite  <= bus.req_write;
            r_pwdata  <= bus.req_wdata;
            r_pprot   <= bus.req_prot;
            // APB4: reads must present an all-zero strobe
            r_pstrb   <= bus.req_write ? bus.req_wstrb : {STRB_W{1'b0}};
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_state   <= S_SETUP;
          end else begin
            r_state   <= S_IDLE;
          end
        end

        S_SETUP: begin
          r_penable  <= 1'b1;
          r_wait_cnt <= {CNT_W{1'b0}};
          r_state    <= S_ACCESS;
        end

        S_ACCESS: begin
          // pready is checked first so it wins over a timeout expiring in the same cycle
          if (bus.out_pready) begin
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_resp_rdata <= r_pwrite ? {DATA_W{1'b0}} : bus.out_prdata;
            r_resp_err   <= bus.out_pslverr;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else if (USE_TO && (r_wait_cnt == CNT_LAST)) begin
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_resp_rdata <= {DATA_W{1'b0}};
            r_resp_err   <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else if (r_wait_cnt != CNT_MAX) begin
            r_wait_cnt   <= r_wait_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            r_wait_cnt   <= r_wait_cnt;
          end
        end

        S_RESP: begin
          // rdata/err keep their last value after the handshake
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_state      <= S_RESP;
          end
        end

        default: begin
          r_psel       <= 1'b0;
          r_penable    <= 1'b0;
          r_resp_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = w_req_ready;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_rdata  = r_resp_rdata;
  assign bus.resp_err    = r_resp_err;
  assign bus.out_paddr   = r_paddr;
  assign bus.out_psel    = r_psel;
  assign bus.out_penable = r_penable;
  assign bus.out_pprot   = r_pprot;
  assign bus.out_pwrite  = r_pwrite;
  assign bus.out_pwdata  = r_pwdata;
  assign bus.out_pstrb   = r_pstrb;

endmodule

// File: tb/tb_apb_req_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_req_bridge
// Directed bench for apb_req_bridge (TIMEOUT=4). The bench changes inputs and
// samples outputs 1 ns after each rising edge. Expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_apb_req_bridge;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  apb_req_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_req_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // free-running 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] pr);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_write = wr;
    bus.req_wdata = wd;
    bus.req_wstrb = st;
    bus.req_prot  = pr;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_addr    = 32'h0;
    bus.req_write   = 1'b0;
    bus.req_wdata   = 32'h0;
    bus.req_wstrb   = 4'h0;
    bus.req_prot    = 3'b000;
    bus.resp_ready  = 1'b1;
    bus.out_pready  = 1'b1;
    bus.out_prdata  = 32'h0;
    bus.out_pslverr = 1'b0;

    // ---------------- reset state
    tick(); tick();
    check_eq("rst_req_ready", {63'd0, bus.req_ready}, 64'd0);
    check_eq("rst_psel", {63'd0, bus.out_psel}, 64'd0);
    check_eq("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    check_eq("rst_paddr", {32'd0, bus.out_paddr}, 64'd0);
    reset = 1'b0;
    #1;
    check_eq("idle_req_ready", {63'd0, bus.req_ready}, 64'd1);

    // ---------------- write, zero wait
    send(32'h1000_2000, 1'b1, 32'h0000_A5A5, 4'b0011, 3'b010);
    tick();                                   // E0
    bus.req_valid = 1'b0;
    check_eq("wr_setup_sel_en", {62'd0, bus.out_psel, bus.out_penable}, 64'd2);
    check_eq("wr_pstrb", {60'd0, bus.out_pstrb}, 64'h3);
    check_eq("wr_paddr", {32'd0, bus.out_paddr}, 64'h1000_2000);
    check_eq("wr_pwdata", {32'd0, bus.out_pwdata}, 64'h0000_A5A5);
    check_eq("wr_pprot_pwrite", {60'd0, bus.out_pprot, bus.out_pwrite}, 64'h5);
    check_eq("wr_busy_ready", {63'd0, bus.req_ready}, 64'd0);
    tick();                                   // E1
    check_eq("wr_access_sel_en", {62'd0, bus.out_psel, bus.out_penable}, 64'd3);
    check_eq("wr_access_rv", {63'd0, bus.resp_valid}, 64'd0);
    tick();                                   // E2
    check_eq("wr_done_sel_en", {62'd0, bus.out_psel, bus.out_penable}, 64'd0);
    check_eq("wr_resp_valid", {63'd0, bus.resp_valid}, 64'd1);
    check_eq("wr_resp_err", {63'd0, bus.resp_err}, 64'd0);
    check_eq("wr_resp_rdata", {32'd0, bus.resp_rdata}, 64'd0);
    tick();                                   // response handshake
    check_eq("wr_rv_clear", {63'd0, bus.resp_valid}, 64'd0);
    check_eq("wr_back_idle", {63'd0, bus.req_ready}, 64'd1);

    // ---------------- read, 3 wait states
    bus.out_pready = 1'b0;
    bus.out_prdata = 32'h1234_5678;
    send(32'h1000_3004, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'b001);
    tick();                                   // E0
    bus.req_valid = 1'b0;
    check_eq("rd_setup_sel_en", {62'd0, bus.out_psel, bus.out_penable}, 64'd2);
    check_eq("rd_pstrb_zero", {60'd0, bus.out_pstrb}, 64'h0);
    for (int i = 1; i <= 4; i++) begin       // E1..E4: four ACCESS cycles
      tick();
      check_eq($sformatf("rd_access%0d_sel_en", i), {62'd0, bus.out_psel, bus.out_penable}, 64'd3);
      check_eq($sformatf("rd_access%0d_paddr", i), {32'd0, bus.out_paddr}, 64'h1000_3004);
      check_eq($sformatf("rd_access%0d_rv", i), {63'd0, bus.resp_valid}, 64'd0);
    end
    bus.out_pready = 1'b1;                    // ready in the 4th ACCESS cycle (boundary with timeout)
    tick();                                   // E5
    check_eq("rd_resp_valid", {63'd0, bus.resp_valid}, 64'd1);
    check_eq("rd_resp_rdata", {32'd0, bus.resp_rdata}, 64'h1234_5678);
    check_eq("rd_resp_err", {63'd0, bus.resp_err}, 64'd0);
    check_eq("rd_done_sel", {63'd0, bus.out_psel}, 64'd0);
    tick();

    // ---------------- slave error
    bus.out_pslverr = 1'b1;
    send(32'hDEAD_0000, 1'b1, 32'h0000_0001, 4'hF, 3'b000);
    tick();
    bus.req_valid = 1'b0;
    tick();
    check_eq("err_access", {62'd0, bus.out_psel, bus.out_penable}, 64'd3);
    tick();
    check_eq("err_resp_valid", {63'd0, bus.resp_valid}, 64'd1);
    check_eq("err_resp_err", {63'd0, bus.resp_err}, 64'd1);
    check_eq("err_sel_drop", {63'd0, bus.out_psel}, 64'd0);
    bus.out_pslverr = 1'b0;
    tick();

    // ---------------- timeout (TIMEOUT=4)
    bus.out_pready = 1'b0;
    bus.out_prdata = 32'h5A5A_5A5A;
    bus.resp_ready = 1'b0;
    send(32'h1000_4000, 1'b0, 32'h0, 4'h0, 3'b000);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_eq($sformatf("to_access%0d_sel", i), {63'd0, bus.out_psel}, 64'd1);
    end
    tick();
    check_eq("to_sel_drop", {62'd0, bus.out_psel, bus.out_penable}, 64'd0);
    check_eq("to_resp_valid", {63'd0, bus.resp_valid}, 64'd1);
    check_eq("to_resp_err", {63'd0, bus.resp_err}, 64'd1);
    check_eq("to_resp_rdata", {32'd0, bus.resp_rdata}, 64'd0);
    bus.out_pready = 1'b1;                    // late pready must be ignored
    tick();
    bus.out_pready = 1'b0;
    tick();
    check_eq("to_late_rdata", {32'd0, bus.resp_rdata}, 64'd0);
    check_eq("to_late_err", {63'd0, bus.resp_err}, 64'd1);
    check_eq("to_late_sel", {63'd0, bus.out_psel}, 64'd0);
    bus.resp_ready = 1'b1;
    tick();
    check_eq("to_rv_clear", {63'd0, bus.resp_valid}, 64'd0);

    // ---------------- back-pressure with a queued second request
    bus.out_pready = 1'b1;
    bus.out_prdata = 32'hCAFE_F00D;
    bus.resp_ready = 1'b0;
    send(32'h1000_5000, 1'b1, 32'h0000_0011, 4'hF, 3'b000);
    tick(); tick(); tick();                   // E0, E1, E2
    check_eq("bp_resp_valid", {63'd0, bus.resp_valid}, 64'd1);
    send(32'h1000_6000, 1'b0, 32'h0, 4'h0, 3'b011);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_eq($sformatf("bp%0d_hold", i), {61'd0, bus.resp_valid, bus.resp_err, bus.req_ready}, 64'h4);
      check_eq($sformatf("bp%0d_rdata", i), {32'd0, bus.resp_rdata}, 64'd0);
      check_eq($sformatf("bp%0d_sel", i), {63'd0, bus.out_psel}, 64'd0);
    end
    bus.resp_ready = 1'b1;
    tick();                                   // handshake edge
    check_eq("bp_hs_rv", {63'd0, bus.resp_valid}, 64'd0);
    check_eq("bp_hs_sel", {63'd0, bus.out_psel}, 64'd0);
    tick();                                   // second request accepted
    bus.req_valid = 1'b0;
    check_eq("bp2_setup", {62'd0, bus.out_psel, bus.out_penable}, 64'd2);
    check_eq("bp2_paddr", {32'd0, bus.out_paddr}, 64'h1000_6000);
    tick(); tick();
    check_eq("bp2_rdata", {32'd0, bus.resp_rdata}, 64'hCAFE_F00D);
    check_eq("bp2_rv", {63'd0, bus.resp_valid}, 64'd1);
    tick();

    // ---------------- reset mid-ACCESS
    bus.out_pready = 1'b0;
    send(32'h1000_7000, 1'b0, 32'h0, 4'h0, 3'b000);
    tick();
    bus.req_valid = 1'b0;
    tick();
    check_eq("mr_in_access", {62'd0, bus.out_psel, bus.out_penable}, 64'd3);
    reset = 1'b1;
    tick();
    check_eq("mr_sel_en", {62'd0, bus.out_psel, bus.out_penable}, 64'd0);
    check_eq("mr_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    check_eq("mr_req_ready_in_rst", {63'd0, bus.req_ready}, 64'd0);
    reset = 1'b0;
    #1;
    check_eq("mr_req_ready_after", {63'd0, bus.req_ready}, 64'd1);
    tick();
    check_eq("mr_idle_sel", {63'd0, bus.out_psel}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
